// File: rtl/relogio_pkg.sv
// Shared types and constants for the digital clock counter chain.
// The mode encoding is visible on the controller's maqc_modo port.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HORA = 2'd1,
    SET_MIN  = 2'd2
  } modo_t;

  localparam int SEG_MAX = 59;
  localparam int MIN_MAX = 59;

  // Counter width for n states, never narrower than one bit.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous button followed by a registered
// rising-edge detector: one-cycle pulse three clocks after the input edge.
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  // sinc[1:0] is the synchronizer, sinc[2] holds the previous synchronized level.
  logic [2:0] sinc;

  // NOTE: non-blocking assignments make every stage sample the pre-edge value,
  // so the chain advances exactly one stage per clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc  <= '0;
      pulso <= 1'b0;
    end else begin
      sinc  <= {sinc[1:0], entrada};
      pulso <= sinc[1] & ~sinc[2];
    end
  end

endmodule

// File: rtl/maq_ctrl.sv
// Sequencing controller for the clock's seconds/minutes/hours machines:
// 1 Hz time base, carry cascade, time-setting mode FSM, timeout and blink.
module maq_ctrl
  import relogio_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic  maqc_clock,
  input  logic  maqc_reset,
  input  logic  maqc_botao_modo,
  input  logic  maqc_botao_inc,
  input  logic  maqc_carry_seg,
  input  logic  maqc_carry_min,
  output logic  maqc_en_seg,
  output logic  maqc_inc_seg,
  output logic  maqc_en_min,
  output logic  maqc_inc_min,
  output logic  maqc_en_hora,
  output logic  maqc_inc_hora,
  output logic  maqc_zera_seg,
  output modo_t maqc_modo,
  output logic  maqc_pisca
);

  localparam int PW   = $clog2(CLK_HZ);
  localparam int HALF = CLK_HZ / 2;
  localparam int BW   = largura(HALF);
  localparam int TW   = $clog2(TIMEOUT_S + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] PISCA_MAX = BW'(HALF - 1);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_S);

  if (CLK_HZ < 2 || (CLK_HZ % 2) != 0) begin : g_clk_hz_invalido
    $error("CLK_HZ must be >= 2 and even");
  end

  if (TIMEOUT_S < 1) begin : g_timeout_invalido
    $error("TIMEOUT_S must be >= 1");
  end

  logic [PW-1:0] presc;
  logic          tick;
  logic          pulso_modo;
  logic          pulso_inc;
  modo_t         modo;
  modo_t         modo_prox;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_cnt_inc;
  logic [BW-1:0] pisca_cnt;
  logic          pisca;
  logic          em_ajuste;
  logic          entra_ajuste;
  logic          sai_ajuste;
  logic          timeout;

  sincroniza_borda u_borda_modo (
    .clock   (maqc_clock),
    .reset   (maqc_reset),
    .entrada (maqc_botao_modo),
    .pulso   (pulso_modo)
  );

  sincroniza_borda u_borda_inc (
    .clock   (maqc_clock),
    .reset   (maqc_reset),
    .entrada (maqc_botao_inc),
    .pulso   (pulso_inc)
  );

  assign em_ajuste  = (modo == SET_HORA) || (modo == SET_MIN);
  assign to_cnt_inc = to_cnt + TW'(1);

  // Expires on the tick that would bring the count to TIMEOUT_S; an increment
  // press in the same cycle restarts the wait instead.
  assign timeout = em_ajuste && tick && !pulso_inc && (to_cnt_inc == TO_LIM);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge maqc_clock or posedge maqc_reset) begin
    if (maqc_reset) begin
      modo <= RUN;
    end else begin
      modo <= modo_prox;
    end
  end

  always_comb begin
    modo_prox = modo;
    case (modo)
      RUN:      if (pulso_modo) modo_prox = SET_HORA;
      SET_HORA: begin
        if (pulso_modo)   modo_prox = SET_MIN;
        else if (timeout) modo_prox = RUN;
      end
      SET_MIN:  if (pulso_modo || timeout) modo_prox = RUN;
      default:  modo_prox = RUN;
    endcase
  end

  assign entra_ajuste = (modo_prox != modo) && (modo_prox != RUN);
  assign sai_ajuste   = em_ajuste && (modo_prox == RUN);

  // NOTE: every output gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    maqc_en_seg   = 1'b0;
    maqc_en_min   = 1'b0;
    maqc_en_hora  = 1'b0;
    maqc_inc_seg  = 1'b0;
    maqc_inc_min  = 1'b0;
    maqc_inc_hora = 1'b0;
    case (modo)
      RUN: begin
        maqc_en_seg   = 1'b1;
        maqc_en_min   = 1'b1;
        maqc_en_hora  = 1'b1;
        maqc_inc_seg  = tick;
        maqc_inc_min  = tick & maqc_carry_seg;
        maqc_inc_hora = tick & maqc_carry_seg & maqc_carry_min;
      end
      SET_HORA: begin
        maqc_en_hora  = 1'b1;
        maqc_inc_hora = pulso_inc & ~pulso_modo;
      end
      SET_MIN: begin
        // carry_min is deliberately ignored: 59 wraps to 00 without touching hours.
        maqc_en_min  = 1'b1;
        maqc_inc_min = pulso_inc & ~pulso_modo;
      end
      default: ;
    endcase
  end

  assign maqc_modo = modo;

  // ---------------------------------------------------------- time base
  // Reloaded on leaving a set mode so the first RUN second is a full second.
  always_ff @(posedge maqc_clock or posedge maqc_reset) begin
    if (maqc_reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (sai_ajuste) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + PW'(1);
      tick  <= 1'b0;
    end
  end

  always_ff @(posedge maqc_clock or posedge maqc_reset) begin
    if (maqc_reset) begin
      maqc_zera_seg <= 1'b0;
    end else begin
      maqc_zera_seg <= sai_ajuste;
    end
  end

  // ------------------------------------------------------------ timeout
  always_ff @(posedge maqc_clock or posedge maqc_reset) begin
    if (maqc_reset) begin
      to_cnt <= '0;
    end else if (modo_prox == RUN || entra_ajuste || pulso_modo || pulso_inc) begin
      to_cnt <= '0;
    end else if (tick) begin
      to_cnt <= to_cnt_inc;
    end
  end

  // -------------------------------------------------------------- blink
  // Forced on at entry and on each increment so the edited value is visible.
  always_ff @(posedge maqc_clock or posedge maqc_reset) begin
    if (maqc_reset) begin
      pisca_cnt <= '0;
      pisca     <= 1'b1;
    end else if (modo_prox == RUN || entra_ajuste || (em_ajuste && pulso_inc)) begin
      pisca_cnt <= '0;
      pisca     <= 1'b1;
    end else if (pisca_cnt == PISCA_MAX) begin
      pisca_cnt <= '0;
      pisca     <= ~pisca;
    end else begin
      pisca_cnt <= pisca_cnt + BW'(1);
    end
  end

  assign maqc_pisca = pisca;

endmodule

// File: doc/maq_ctrl.md
Name: maq_ctrl

Overview:
Sequencing controller for the digital clock's counter chain (seconds, minutes and hours machines).
- Generates the 1 Hz time base.
- Cascades the carries: seconds carry increments minutes; seconds and minutes carries together increment hours.
- Runs the time-setting mode FSM from two externally debounced buttons.
- Drives display blinking for the field being set.
- Sits between the button inputs and the counter machines; drives their enable and increment inputs.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz; the prescaler divides by this value.
- TIMEOUT_S, 10, seconds without button activity before a set mode automatically returns to RUN.

Ports:
- maqc_clock  input  1  system clock.
- maqc_reset  input  1  asynchronous, active-high reset.
- maqc_botao_modo  input  1  mode button, debounced, asynchronous to the clock.
- maqc_botao_inc  input  1  increment button, debounced, asynchronous to the clock.
- maqc_carry_seg  input  1  seconds machine at 59, combinational from that machine.
- maqc_carry_min  input  1  minutes machine at 59 (its incrementa_hora output).
- maqc_en_seg  output  1  enable to the seconds machine.
- maqc_inc_seg  output  1  increment pulse to the seconds machine.
- maqc_en_min  output  1  enable to the minutes machine.
- maqc_inc_min  output  1  increment pulse to the minutes machine.
- maqc_en_hora  output  1  enable to the hours machine.
- maqc_inc_hora  output  1  increment pulse to the hours machine.
- maqc_zera_seg  output  1  one-cycle clear of the seconds machine.
- maqc_modo  output  2  current mode, type modo_t.
- maqc_pisca  output  1  display-on for the selected field (1 = show digits).

Behaviour:
- Reset (async, active-high): modo = RUN, prescaler = 0, timeout counter = 0, blink counter = 0, pisca = 1, zera_seg = 0, synchronizer and edge flops = 0. All inc_* outputs are therefore 0. Reset mid-set returns the block to RUN.
- Prescaler: counts 0 .. CLK_HZ-1. The registered one-cycle pulse tick goes high when the count wraps. The prescaler runs in every mode.
- Buttons: each passes through a 2-FF synchronizer, then a rising-edge detector. The result is a one-cycle pulse (pulso_modo, pulso_inc). Latency is 3 cycles from a button input edge to its pulse.
- Enables, combinational from modo:
  - RUN: en_seg = en_min = en_hora = 1.
  - SET_HORA: en_hora = 1 only.
  - SET_MIN: en_min = 1 only.
- Increments, combinational so the counters sample on the same edge:
  - RUN: inc_seg = tick; inc_min = tick & carry_seg; inc_hora = tick & carry_seg & carry_min.
  - SET_HORA: inc_hora = pulso_inc; all other inc_* = 0.
  - SET_MIN: inc_min = pulso_inc; inc_hora = 0 even when carry_min = 1, so 59 wraps to 00 without touching hours.
  - Increments are ignored in the set modes when pulso_modo is high in the same cycle.
- FSM on pulso_modo: RUN -> SET_HORA -> SET_MIN -> RUN.
- pulso_modo and pulso_inc in the same cycle: the mode transition wins and the increment is dropped.
- Exit to RUN: on the SET_MIN -> RUN transition (button or timeout), the block registers zera_seg = 1 for exactly one cycle and reloads the prescaler to 0. The first tick in RUN then arrives CLK_HZ cycles later.
- Timeout:
  - Active only in SET_HORA and SET_MIN.
  - Counts ticks; cleared by any pulso_modo, any pulso_inc, or entry to a set mode.
  - When the count reaches TIMEOUT_S, modo becomes RUN with the same zera_seg and prescaler reload as above. This applies from SET_HORA as well.
- Blink:
  - RUN: pisca = 1 constantly.
  - Set modes: pisca toggles every CLK_HZ/2 cycles (1 Hz, 50% duty).
  - On entering a set mode and on every pulso_inc, pisca is forced to 1 and the blink counter restarts.
- Width rules:
  - Prescaler width = $clog2(CLK_HZ).
  - Timeout counter width = $clog2(TIMEOUT_S+1).
  - CLK_HZ must be >= 2 and even.

Decomposition:
- Package relogio_pkg holds:
  - typedef enum logic [1:0] modo_t {RUN = 2'd0, SET_HORA = 2'd1, SET_MIN = 2'd2}; value 2'd3 is illegal and recovers to RUN.
  - Shared constants SEG_MAX = 59 and MIN_MAX = 59.
- Sub-module sincroniza_borda holds the 2-FF synchronizer plus rising-edge pulse. It is instantiated twice (mode and increment buttons).

Test Plan (CLK_HZ = 4, TIMEOUT_S = 3):
- Reset, then run 12 cycles with carry inputs = 0 -> modo = RUN, en_* = 1, inc_seg pulses on cycles 4, 8 and 12, inc_min = inc_hora = 0, pisca = 1.
- Hold carry_seg = 1 and carry_min = 1 at a tick -> inc_seg, inc_min and inc_hora are all 1 in that same cycle. With carry_min = 0 -> only inc_seg and inc_min are 1.
- Press mode once, then inc twice -> modo = SET_HORA, en_hora = 1 only, two single-cycle inc_hora pulses, each 3 cycles after its button edge, inc_seg = 0 throughout.
- In SET_MIN with carry_min = 1, press inc -> inc_min = 1 and inc_hora = 0. Then press mode -> modo = RUN, zera_seg high for exactly 1 cycle, first inc_seg exactly 4 cycles later.
- In SET_HORA, press nothing for 12 cycles -> modo = RUN after the 3rd tick, zera_seg pulses once. Pisca toggles every 2 cycles before the exit and is constant 1 after it.
- Mode and inc edges in the same cycle in SET_HORA -> modo = SET_MIN, no inc_hora. Assert reset mid-SET_MIN -> modo = RUN immediately and all inc_* = 0.
